// File: rtl/usb_rx_nrzi_decoder_pkg.sv
// usb_rx_nrzi_decoder_pkg: shared symbol encodings, FSM states and constants for the USB receive front end
package usb_rx_nrzi_decoder_pkg;
  typedef enum logic [1:0] {SYM_SE0 = 2'd0, SYM_J = 2'd1, SYM_K = 2'd2, SYM_SE1 = 2'd3} sym_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_WAIT_J} state_t;
  // 1 = J, 0 = K, bit 0 is the first symbol on the line
  localparam logic [7:0] SYNC_PATTERN = 8'b0010_1010;
  localparam int MAX_ONES_DEF = 6;
  function automatic sym_t classify(input logic [1:0] sig, input logic [1:0] j, input logic [1:0] k);
    if (sig == j) return SYM_J;
    if (sig == k) return SYM_K;
    if (sig == 2'b00) return SYM_SE0;
    return SYM_SE1;
  endfunction
endpackage

// File: rtl/usb_rx_nrzi_decoder_bit_sampler.sv
// usb_rx_nrzi_decoder_bit_sampler: edge-aligned mid-bit sampling and J/K/SE0/SE1 classification
module usb_rx_nrzi_decoder_bit_sampler
  import usb_rx_nrzi_decoder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_bus_reset,
  input  logic [1:0] i_usb_signals,
  input  logic [1:0] i_j_state,
  input  logic [1:0] i_k_state,
  output sym_t       o_sym,
  output logic       o_sym_valid
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  logic [1:0]    r_prev_sig;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase;
  logic          w_edge;
  // the cycle carrying a new line level is phase 0 of its bit
  always_comb begin
    w_edge      = i_usb_signals != r_prev_sig;
    w_phase     = w_edge ? '0 : (r_phase == PW'(CLKS_PER_BIT - 1)) ? '0 : r_phase + 1'b1;
    o_sym_valid = w_phase == PW'(CLKS_PER_BIT / 2);
    o_sym       = classify(i_usb_signals, i_j_state, i_k_state);
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev_sig <= 2'b00;
      r_phase    <= '0;
    end else begin
      r_prev_sig <= i_usb_signals;
      r_phase    <= i_bus_reset ? '0 : w_phase;
    end
  end
endmodule

// File: rtl/usb_rx_nrzi_decoder.sv
// usb_rx_nrzi_decoder: SYNC detect, NRZI decode, bit unstuffing and EOP detect producing a framed serial bit stream
module usb_rx_nrzi_decoder
  import usb_rx_nrzi_decoder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_ONES     = MAX_ONES_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [1:0] i_usb_signals,
  input  logic [1:0] i_j_state,
  input  logic [1:0] i_k_state,
  input  logic       i_bus_reset,
  output logic [1:0] o_line_state,
  output logic       o_rx_active,
  output logic       o_rx_bit,
  output logic       o_rx_bit_valid,
  output logic       o_rx_sop,
  output logic       o_rx_eop,
  output logic       o_rx_error
);
  localparam int OW = $clog2(MAX_ONES + 1);
  sym_t          w_sym;
  logic          w_sym_valid;
  logic          w_nrzi;
  state_t        r_state, w_state;
  logic [2:0]    r_cnt, w_cnt;
  sym_t          r_prev, w_prev;
  logic [OW-1:0] r_ones, w_ones;
  sym_t          r_line, w_line;
  logic          r_active, w_active;
  logic          r_bit, w_bit;
  logic          r_valid, w_valid;
  logic          r_sop, w_sop;
  logic          r_eop, w_eop;
  logic          r_err, w_err;

  usb_rx_nrzi_decoder_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_bus_reset  (i_bus_reset),
    .i_usb_signals(i_usb_signals),
    .i_j_state    (i_j_state),
    .i_k_state    (i_k_state),
    .o_sym        (w_sym),
    .o_sym_valid  (w_sym_valid)
  );

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_prev   = r_prev;
    w_ones   = r_ones;
    w_active = r_active;
    w_bit    = r_bit;
    w_valid  = 1'b0;
    w_sop    = 1'b0;
    w_eop    = 1'b0;
    w_err    = 1'b0;
    w_line   = w_sym_valid ? w_sym : r_line;
    w_nrzi   = w_sym == r_prev;
    if (i_bus_reset) begin
      w_state  = ST_IDLE;
      w_cnt    = '0;
      w_ones   = '0;
      w_active = 1'b0;
    end else if (w_sym_valid) begin
      case (r_state)
        ST_IDLE: if (w_sym == SYM_K) begin
          w_state = ST_SYNC;
          w_cnt   = 3'd1;
        end
        ST_SYNC: if (w_sym != (SYNC_PATTERN[r_cnt] ? SYM_J : SYM_K)) begin
          w_err   = 1'b1;
          w_state = ST_WAIT_J;
        end else if (r_cnt == 3'd7) begin
          w_sop    = 1'b1;
          w_active = 1'b1;
          w_prev   = SYM_K;
          w_ones   = '0;
          w_state  = ST_DATA;
        end else
          w_cnt = r_cnt + 3'd1;
        ST_DATA: if (w_sym == SYM_J || w_sym == SYM_K) begin
          w_prev = w_sym;
          // after MAX_ONES ones the next bit is a stuffed 0 and is swallowed
          if (r_ones == OW'(MAX_ONES)) begin
            w_ones   = '0;
            w_err    = w_nrzi;
            w_active = !w_nrzi;
            w_state  = w_nrzi ? ST_WAIT_J : ST_DATA;
          end else begin
            w_valid = 1'b1;
            w_bit   = w_nrzi;
            w_ones  = w_nrzi ? r_ones + 1'b1 : '0;
          end
        end else if (w_sym == SYM_SE0) begin
          w_state = ST_EOP;
          w_cnt   = 3'd1;
        end else begin
          w_err    = 1'b1;
          w_active = 1'b0;
          w_state  = ST_WAIT_J;
        end
        ST_EOP: if (w_sym == SYM_SE0 && r_cnt < 3'd2)
          w_cnt = r_cnt + 3'd1;
        else if (w_sym == SYM_J && r_cnt == 3'd2) begin
          w_eop    = 1'b1;
          w_active = 1'b0;
          w_state  = ST_IDLE;
        end else begin
          w_err    = 1'b1;
          w_active = 1'b0;
          w_state  = ST_WAIT_J;
        end
        ST_WAIT_J: w_state = (w_sym == SYM_J) ? ST_IDLE : ST_WAIT_J;
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_prev   <= SYM_K;
      r_ones   <= '0;
      r_line   <= SYM_J;
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_prev   <= w_prev;
      r_ones   <= w_ones;
      r_line   <= w_line;
      r_active <= w_active;
      r_bit    <= w_bit;
      r_valid  <= w_valid;
      r_sop    <= w_sop;
      r_eop    <= w_eop;
      r_err    <= w_err;
    end
  end

  assign o_line_state   = r_line;
  assign o_rx_active    = r_active;
  assign o_rx_bit       = r_bit;
  assign o_rx_bit_valid = r_valid;
  assign o_rx_sop       = r_sop;
  assign o_rx_eop       = r_eop;
  assign o_rx_error     = r_err;
endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// tb_usb_rx_nrzi_decoder: directed packets with a scoreboard of expected framing/bit events
module tb_usb_rx_nrzi_decoder;
  localparam int SE0 = 0, J = 1, K = 2, SE1 = 3;
  localparam int EV_SOP = 2, EV_EOP = 3, EV_ERR = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_reset = 1'b0;
  logic [1:0] usb = 2'b10;
  logic [1:0] j_st = 2'b10;
  logic [1:0] k_st = 2'b01;
  logic [1:0] line_state;
  logic       rx_active, rx_bit, rx_bit_valid, rx_sop, rx_eop, rx_error;
  int         checks = 0;
  int         errors = 0;
  int         q[$];
  int         lvl = K;
  int         ones = 0;
  bit         alt = 1'b0;
  bit         alt_ph = 1'b0;

  usb_rx_nrzi_decoder dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_usb_signals (usb),
    .i_j_state     (j_st),
    .i_k_state     (k_st),
    .i_bus_reset   (bus_reset),
    .o_line_state  (line_state),
    .o_rx_active   (rx_active),
    .o_rx_bit      (rx_bit),
    .o_rx_bit_valid(rx_bit_valid),
    .o_rx_sop      (rx_sop),
    .o_rx_eop      (rx_eop),
    .o_rx_error    (rx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic ev(input int got);
    int e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %0d expected none", got);
    end else begin
      e = q.pop_front();
      check("event", got, e);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rx_bit_valid) ev(int'(rx_bit));
    if (rx_sop) ev(EV_SOP);
    if (rx_eop) ev(EV_EOP);
    if (rx_error) ev(EV_ERR);
  end

  task automatic sym(input int s, input int n = 1);
    for (int i = 0; i < n; i++) begin
      usb = (s == J) ? j_st : (s == K) ? k_st : (s == SE0) ? 2'b00 : 2'b11;
      repeat (alt ? (alt_ph ? 5 : 3) : 4) @(negedge clk);
      alt_ph = !alt_ph;
    end
  endtask

  task automatic send_sync();
    q.push_back(EV_SOP);
    sym(K); sym(J); sym(K); sym(J); sym(K); sym(J); sym(K); sym(K);
    lvl  = K;
    ones = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input int nb);
    for (int i = 0; i < nb; i++) q.push_back(int'(d[i]));
  endtask

  // NRZI line encoder with optional bit stuffing
  task automatic send_byte(input logic [7:0] d, input bit stuff, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (stuff && ones == 6) begin
        lvl  = 3 - lvl;
        ones = 0;
        sym(lvl);
      end
      if (d[i]) ones++;
      else begin
        lvl  = 3 - lvl;
        ones = 0;
      end
      sym(lvl);
    end
  endtask

  task automatic send_eop();
    q.push_back(EV_EOP);
    sym(SE0, 2);
    sym(J);
  endtask

  task automatic packet(input logic [7:0] d);
    send_sync();
    push_byte(d, 8);
    send_byte(d, 1'b1, 8);
    check("pkt_active", int'(rx_active), 1);
    send_eop();
    check("pkt_active_end", int'(rx_active), 0);
    sym(J, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (6) begin
      usb = 2'($urandom);
      @(negedge clk);
    end
    check("rst_active", int'(rx_active), 0);
    check("rst_line", int'(line_state), 1);
    check("rst_pulses", int'({rx_bit_valid, rx_sop, rx_eop, rx_error, rx_bit}), 0);
    rst_n = 1'b1;
    sym(J, 4);
    check("idle_active", int'(rx_active), 0);
    check("idle_line", int'(line_state), 1);
    packet(8'hA5);
    packet(8'hFF);
    send_sync();
    push_byte(8'hFF, 6);
    q.push_back(EV_ERR);
    send_byte(8'hFF, 1'b0, 8);
    check("nostuff_active", int'(rx_active), 0);
    sym(J, 2);
    q.push_back(EV_ERR);
    sym(K); sym(J); sym(J);
    check("badsync_active", int'(rx_active), 0);
    sym(J, 2);
    packet(8'h5A);
    alt = 1'b1;
    packet(8'h3C);
    alt = 1'b0;
    send_sync();
    push_byte(8'h96, 4);
    send_byte(8'h96, 1'b1, 4);
    check("busrst_active_before", int'(rx_active), 1);
    bus_reset = 1'b1;
    usb = j_st;
    @(negedge clk);
    bus_reset = 1'b0;
    check("busrst_active_after", int'(rx_active), 0);
    sym(J, 4);
    j_st = 2'b01;
    k_st = 2'b10;
    sym(J, 4);
    check("ls_line", int'(line_state), 1);
    packet(8'hA5);
    sym(J, 4);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
